// File: rtl/fir_xif_offloader_pkg.sv
// Shared types, opcode constants and field helpers for the core-side FIR X-IF offloader.
package fir_xif_offloader_pkg;

    localparam int XIF_ID_WIDTH = 4;

    localparam logic [6:0] OPC_FIR     = 7'b1011011;
    localparam logic [2:0] F3_XFIRLW   = 3'b000;
    localparam logic [2:0] F3_XFIRSW   = 3'b001;
    localparam logic [2:0] F3_XFIRDOTP = 3'b010;

    typedef struct packed {
        logic [31:0]             instr;
        logic [XIF_ID_WIDTH-1:0] id;
        logic [31:0]             rs1;
        logic [31:0]             rs2;
    } xif_issue_req_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic                    kill;
    } xif_commit_t;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic [31:0]             data;
        logic [4:0]              rd;
        logic                    we;
    } xif_result_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } offload_state_t;

    function automatic logic [6:0] get_opcode(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [2:0] get_funct3(input logic [31:0] instr);
        return instr[14:12];
    endfunction

    function automatic logic is_fir_instr(input logic [31:0] instr);
        return (get_opcode(instr) == OPC_FIR) &&
               (get_funct3(instr) inside {F3_XFIRLW, F3_XFIRSW, F3_XFIRDOTP});
    endfunction

endpackage

// File: rtl/fir_xif_offloader_id_tracker.sv
// Per-id outstanding/writeback bookkeeping for the offloader, with live count and full flag.
module fir_xif_id_tracker #(
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_en,
    input  logic [ID_W-1:0]  alloc_id,
    input  logic             alloc_wb,
    input  logic             clear_en,
    input  logic [ID_W-1:0]  clear_id,
    input  logic             kill_en,
    input  logic [ID_W-1:0]  kill_id,
    input  logic [ID_W-1:0]  query_id,
    output logic             query_valid,
    output logic             query_wb,
    input  logic [ID_W-1:0]  next_id,
    output logic             next_busy,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    localparam int NUM_IDS = 2 ** ID_W;

    logic [NUM_IDS-1:0] valid_q, valid_d;
    logic [NUM_IDS-1:0] wb_q, wb_d;

    // Releases first, allocation last; the stall rule keeps alloc_id off live entries.
    always_comb begin
        valid_d = valid_q;
        wb_d    = wb_q;
        if (clear_en) valid_d[clear_id] = 1'b0;
        if (kill_en)  valid_d[kill_id]  = 1'b0;
        if (alloc_en) begin
            valid_d[alloc_id] = 1'b1;
            wb_d[alloc_id]    = alloc_wb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            wb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            count = count + CNT_W'(valid_q[i]);
        end
    end

    assign full        = (count == CNT_W'(MAX_OUT));
    assign query_valid = valid_q[query_id];
    assign query_wb    = wb_q[query_id];
    assign next_busy   = valid_q[next_id];

endmodule

// File: rtl/fir_xif_offloader.sv
// Core-side CV-X-IF initiator: offloads FIR opcodes, runs issue/commit, retires results to the GPR port.
//   state  | meaning
//   IDLE   | waiting for a legal, unstalled FIR instruction
//   ISSUE  | x_issue_* held stable until the coprocessor handshakes
//   COMMIT | one-cycle commit/kill strobe for the issued id
module fir_xif_offloader
    import fir_xif_offloader_pkg::*;
#(
    parameter int X_ID_WIDTH      = XIF_ID_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 instr_valid_i,
    output logic                                 instr_ready_o,
    input  logic [31:0]                          instr_i,
    input  logic [31:0]                          rs1_val_i,
    input  logic [31:0]                          rs2_val_i,
    input  logic                                 kill_i,
    output logic                                 x_issue_valid_o,
    input  logic                                 x_issue_ready_i,
    output logic [31:0]                          x_issue_instr_o,
    output logic [X_ID_WIDTH-1:0]                x_issue_id_o,
    output logic [31:0]                          x_issue_rs1_o,
    output logic [31:0]                          x_issue_rs2_o,
    input  logic                                 x_issue_accept_i,
    input  logic                                 x_issue_writeback_i,
    output logic                                 x_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]                x_commit_id_o,
    output logic                                 x_commit_kill_o,
    input  logic                                 x_result_valid_i,
    output logic                                 x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]                x_result_id_i,
    input  logic [31:0]                          x_result_data_i,
    input  logic [4:0]                           x_result_rd_i,
    input  logic                                 x_result_we_i,
    output logic                                 gpr_we_o,
    output logic [4:0]                           gpr_waddr_o,
    output logic [31:0]                          gpr_wdata_o,
    output logic                                 illegal_o,
    output logic                                 protocol_err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    offload_state_t        state_q, state_d;
    xif_issue_req_t        issue_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic                  wb_pending_q;

    logic fir_ok, stall, load_issue, alloc_en, release_en;
    logic res_hit, res_killed, gpr_we_d;
    logic trk_full, trk_next_busy, trk_q_valid, trk_q_wb;

    assign fir_ok     = is_fir_instr(instr_i);
    assign stall      = trk_full | trk_next_busy;
    assign load_issue = (state_q == IDLE) && (state_d == ISSUE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid_i && fir_ok && !stall) state_d = ISSUE;
            ISSUE:   if (x_issue_ready_i) state_d = x_issue_accept_i ? COMMIT : IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset so every strobe reads 0 while reset is held.
    always_comb begin
        instr_ready_o    = 1'b0;
        illegal_o        = 1'b0;
        x_issue_valid_o  = 1'b0;
        x_commit_valid_o = 1'b0;
        x_commit_kill_o  = 1'b0;
        alloc_en         = 1'b0;
        if (rst_ni) begin
            case (state_q)
                IDLE: begin
                    if (instr_valid_i && !fir_ok) begin
                        instr_ready_o = 1'b1;
                        illegal_o     = 1'b1;
                    end
                end
                ISSUE: begin
                    x_issue_valid_o = 1'b1;
                    if (x_issue_ready_i) begin
                        instr_ready_o = 1'b1;
                        alloc_en      = x_issue_accept_i;
                        illegal_o     = !x_issue_accept_i;
                    end
                end
                COMMIT: begin
                    x_commit_valid_o = 1'b1;
                    x_commit_kill_o  = kill_i;
                end
                default: ;
            endcase
        end
    end

    // A killed id or one that will never return a result is released at commit.
    assign release_en = x_commit_valid_o && (kill_i || !wb_pending_q);
    assign res_hit    = x_result_valid_i && trk_q_valid;
    assign res_killed = x_commit_kill_o && (x_result_id_i == issue_q.id);
    assign gpr_we_d   = res_hit && !res_killed && x_result_we_i && trk_q_wb;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            issue_q        <= '0;
            id_q           <= '0;
            wb_pending_q   <= 1'b0;
            gpr_we_o       <= 1'b0;
            gpr_waddr_o    <= '0;
            gpr_wdata_o    <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (load_issue) begin
                issue_q <= '{instr: instr_i, id: id_q, rs1: rs1_val_i, rs2: rs2_val_i};
            end
            if (alloc_en) wb_pending_q <= x_issue_writeback_i;
            if (state_q == COMMIT) id_q <= id_q + X_ID_WIDTH'(1);
            gpr_we_o <= gpr_we_d;
            if (gpr_we_d) begin
                gpr_waddr_o <= x_result_rd_i;
                gpr_wdata_o <= x_result_data_i;
            end
            if (x_result_valid_i && !trk_q_valid) protocol_err_o <= 1'b1;
        end
    end

    assign x_issue_instr_o  = issue_q.instr;
    assign x_issue_id_o     = issue_q.id;
    assign x_issue_rs1_o    = issue_q.rs1;
    assign x_issue_rs2_o    = issue_q.rs2;
    assign x_commit_id_o    = issue_q.id;
    assign x_result_ready_o = 1'b1;

    fir_xif_id_tracker #(
        .ID_W    (X_ID_WIDTH),
        .MAX_OUT (MAX_OUTSTANDING),
        .CNT_W   (CNT_W)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_en    (alloc_en),
        .alloc_id    (issue_q.id),
        .alloc_wb    (x_issue_writeback_i),
        .clear_en    (res_hit),
        .clear_id    (x_result_id_i),
        .kill_en     (release_en),
        .kill_id     (issue_q.id),
        .query_id    (x_result_id_i),
        .query_valid (trk_q_valid),
        .query_wb    (trk_q_wb),
        .next_id     (id_q),
        .next_busy   (trk_next_busy),
        .count       (outstanding_o),
        .full        (trk_full)
    );

endmodule
